// File: rtl/uart_loader.sv
// uart_loader: 8N1 UART receiver feeding a program-image loader that writes
// little-endian packed words to a RAM write port and holds the CPU in reset
// while an image is in flight.
// Optional feature: define UART_LOADER_CHECKSUM_EN to require a trailing
// mod-256 checksum byte after the data words.
module uart_loader #(
    parameter int unsigned CLK_HZ        = 40000000,
    parameter int unsigned SCLK_HZ       = 115200,
    parameter int unsigned COUNTER_WIDTH = 9,
    parameter int unsigned WIDTH_D       = 32,
    parameter int unsigned DEPTH_A       = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               uart_rxd,
    output logic               mem_we,
    output logic [DEPTH_A-1:0] mem_addr,
    output logic [WIDTH_D-1:0] mem_d,
    output logic               cpu_reset,
    output logic               done,
    output logic               error
);
    localparam int unsigned BIT    = CLK_HZ / SCLK_HZ;
    localparam int unsigned BPW    = WIDTH_D / 8;
    localparam int unsigned LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_FULL  = COUNTER_WIDTH'(BIT - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_HALF  = COUNTER_WIDTH'(BIT / 2 - 1);
    localparam logic [LANE_W-1:0]        LANE_LAST = LANE_W'(BPW - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_HDR0, L_HDR1, L_DATA, L_CHK, L_FIN} ld_state_t;

    logic                     rxd_s1_q, rxd_s2_q, rxd_prev_q;
    rx_state_t                rx_state_q, rx_state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [7:0]               shreg_q, shreg_d;
    logic                     byte_valid_c, frame_err_c;

    ld_state_t                ld_state_q, ld_state_d;
    logic [DEPTH_A-1:0]       addr_q, addr_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [15:0]              words_left_q, words_left_d;
    logic [7:0]               n_lo_q, n_lo_d;
    logic [WIDTH_D-1:0]       word_q, word_d;
    logic                     mem_we_q, mem_we_d;
    logic [DEPTH_A-1:0]       mem_addr_q, mem_addr_d;
    logic [WIDTH_D-1:0]       mem_d_q, mem_d_d;
    logic                     cpu_reset_q, cpu_reset_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]               sum_q, sum_d;
`endif

    // Two-flop synchronizer plus one delayed copy for start-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_s1_q   <= uart_rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
        end
    end

    // Receiver and loader state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q   <= R_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            ld_state_q   <= L_HDR0;
            addr_q       <= '0;
            lane_q       <= '0;
            words_left_q <= '0;
            n_lo_q       <= '0;
            word_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_d_q      <= '0;
            cpu_reset_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            ld_state_q   <= ld_state_d;
            addr_q       <= addr_d;
            lane_q       <= lane_d;
            words_left_q <= words_left_d;
            n_lo_q       <= n_lo_d;
            word_q       <= word_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_d_q      <= mem_d_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    // 8N1 receiver: mid-bit sampling; requires a 1->0 edge, so a held-low line is ignored
    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        byte_valid_c = 1'b0;
        frame_err_c  = 1'b0;
        unique case (rx_state_q)
            R_IDLE: begin
                if (rxd_prev_q && !rxd_s2_q) begin
                    rx_state_d = R_START;
                    cnt_d      = CNT_HALF;
                end
            end
            R_START: begin
                if (cnt_q == '0) begin
                    if (!rxd_s2_q) begin
                        rx_state_d = R_DATA;
                        cnt_d      = CNT_FULL;
                        bit_idx_d  = '0;
                    end else begin
                        rx_state_d = R_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - COUNTER_WIDTH'(1);
                end
            end
            R_DATA: begin
                if (cnt_q == '0) begin
                    shreg_d = {rxd_s2_q, shreg_q[7:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - COUNTER_WIDTH'(1);
                end
            end
            R_STOP: begin
                if (cnt_q == '0) begin
                    byte_valid_c = rxd_s2_q;
                    frame_err_c  = !rxd_s2_q;
                    rx_state_d   = R_IDLE;
                end else begin
                    cnt_d = cnt_q - COUNTER_WIDTH'(1);
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // Loader: header parse, lane packing, write strobe, completion and error handling
    always_comb begin
        ld_state_d   = ld_state_q;
        addr_d       = addr_q;
        lane_d       = lane_q;
        words_left_d = words_left_q;
        n_lo_d       = n_lo_q;
        word_d       = word_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_d_d      = mem_d_q;
        cpu_reset_d  = cpu_reset_q;
        done_d       = 1'b0;
        error_d      = error_q;
`ifdef UART_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        unique case (ld_state_q)
            L_HDR0: begin
                if (byte_valid_c) begin
                    n_lo_d      = shreg_q;
                    cpu_reset_d = 1'b1;
                    error_d     = 1'b0;
                    addr_d      = '0;
                    lane_d      = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d       = '0;
`endif
                    ld_state_d  = L_HDR1;
                end
            end
            L_HDR1: begin
                if (byte_valid_c) begin
                    if ({shreg_q, n_lo_q} == 16'd0) begin
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                        ld_state_d  = L_HDR0;
                    end else begin
                        words_left_d = {shreg_q, n_lo_q};
                        ld_state_d   = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (byte_valid_c) begin
                    word_d[{lane_q, 3'b000} +: 8] = shreg_q;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d = sum_q + shreg_q;
`endif
                    if (lane_q == LANE_LAST) begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = addr_q;
                        mem_d_d      = word_d;
                        addr_d       = addr_q + DEPTH_A'(1);
                        lane_d       = '0;
                        words_left_d = words_left_q - 16'd1;
                        if (words_left_q == 16'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                            ld_state_d = L_CHK;
`else
                            ld_state_d = L_FIN;
`endif
                        end
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            L_CHK: begin
`ifdef UART_LOADER_CHECKSUM_EN
                if (byte_valid_c) begin
                    if (shreg_q == sum_q) begin
                        ld_state_d = L_FIN;
                    end else begin
                        error_d     = 1'b1;
                        cpu_reset_d = 1'b0;
                        ld_state_d  = L_HDR0;
                    end
                end
`else
                ld_state_d = L_HDR0;
`endif
            end
            L_FIN: begin
                done_d      = 1'b1;
                cpu_reset_d = 1'b0;
                ld_state_d  = L_HDR0;
            end
            default: ld_state_d = L_HDR0;
        endcase
        // A framing error discards the byte and abandons the image
        if (frame_err_c) begin
            error_d     = 1'b1;
            cpu_reset_d = 1'b0;
            ld_state_d  = L_HDR0;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_d     = mem_d_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_uart_loader.sv
// Testbench for uart_loader: drives UART frames, predicts writes/done/error
// from the image bytes, and checks every write and done pulse as it happens.
module tb_uart_loader;
    localparam int unsigned BIT = 16;
    localparam int unsigned AW  = 3;

    logic          clk;
    logic          reset_n;
    logic          uart_rxd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_d;
    logic          cpu_reset;
    logic          done;
    logic          error;

    uart_loader #(
        .CLK_HZ(1600), .SCLK_HZ(100), .COUNTER_WIDTH(5), .WIDTH_D(32), .DEPTH_A(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .uart_rxd(uart_rxd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_d(mem_d),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           last_we_cyc = 0;
    int           done_seen = 0;
    bit           exp_done_armed = 1'b0;
    bit           need_adjacent = 1'b0;
    logic [7:0]   img[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]  exp_data[$];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: little-endian word w of the image, address modulo memory size
    function automatic logic [31:0] model_word(input int w);
        return {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
    endfunction

    function automatic logic [AW-1:0] model_addr(input int w);
        return AW'(w % (1 << AW));
    endfunction

    function automatic logic [7:0] model_sum();
        logic [7:0] s;
        s = 8'h00;
        foreach (img[i]) s = s + img[i];
        return s;
    endfunction

    // Per-cycle compare of write strobes and done pulses against the expectation queues
    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (mem_we) begin
                check_eq("we_expected", 32'(exp_addr.size() > 0), 32'd1);
                if (exp_addr.size() > 0) begin
                    check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr[0]));
                    check_eq("mem_d", mem_d, exp_data[0]);
                    check_eq("cpu_reset_at_we", 32'(cpu_reset), 32'd1);
                    void'(exp_addr.pop_front());
                    void'(exp_data.pop_front());
                end
                last_we_cyc = cyc;
            end
            if (done) begin
                check_eq("done_expected", 32'(exp_done_armed), 32'd1);
                check_eq("done_writes_drained", 32'(exp_addr.size()), 32'd0);
                check_eq("done_cpu_reset", 32'(cpu_reset), 32'd0);
                if (need_adjacent) check_eq("done_latency", 32'(cyc - last_we_cyc), 32'd1);
                exp_done_armed = 1'b0;
                done_seen++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rxd = stop_ok;
        repeat (BIT) @(negedge clk);
        uart_rxd = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    // Send a complete image from img[] and check its end state
    task automatic run_image(input int n, input bit chk_good);
        int nd0;
        bit ok;
        ok = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
        ok = chk_good;
`endif
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(model_addr(w));
            exp_data.push_back(model_word(w));
        end
        exp_done_armed = ok;
        need_adjacent = (n > 0);
`ifdef UART_LOADER_CHECKSUM_EN
        need_adjacent = 1'b0;
`endif
        nd0 = done_seen;
        send_byte(8'(n), 1'b1);
        check_eq("cpu_reset_after_hdr0", 32'(cpu_reset), 32'd1);
        check_eq("error_cleared_by_hdr0", 32'(error), 32'd0);
        send_byte(8'(n >> 8), 1'b1);
        foreach (img[i]) send_byte(img[i], 1'b1);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(chk_good ? model_sum() : model_sum() + 8'd1, 1'b1);
`endif
        repeat (8) @(negedge clk);
        check_eq("done_count", 32'(done_seen - nd0), ok ? 32'd1 : 32'd0);
        check_eq("writes_drained", 32'(exp_addr.size()), 32'd0);
        check_eq("cpu_reset_end", 32'(cpu_reset), 32'd0);
        check_eq("error_end", 32'(error), ok ? 32'd0 : 32'd1);
        exp_addr.delete();
        exp_data.delete();
        exp_done_armed = 1'b0;
        need_adjacent = 1'b0;
        if (chk_good) img.delete();
    endtask

    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    endtask

    initial begin
        reset_n  = 1'b1;
        uart_rxd = 1'b1;
        #3 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_d", mem_d, 32'd0);
        check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Example image, with the model pinned to hand-computed words
        img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        check_eq("model_word0", model_word(0), 32'h12345678);
        check_eq("model_word1", model_word(1), 32'hDEADBEEF);
        check_eq("model_addr_wrap", 32'(model_addr(9)), 32'd1);
        run_image(2, 1'b1);

        // Empty image
        img.delete();
        run_image(0, 1'b1);

        // Short low glitch on idle line
        uart_rxd = 1'b0;
        repeat (BIT / 4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check_eq("glitch_error", 32'(error), 32'd0);
        check_eq("glitch_cpu_reset", 32'(cpu_reset), 32'd0);
        fill_random(1);
        run_image(1, 1'b1);

        // Framing error in the middle of an image, then recovery
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("frame_err_error", 32'(error), 32'd1);
        check_eq("frame_err_cpu_reset", 32'(cpu_reset), 32'd0);
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_eq("model_word_recover", model_word(0), 32'h44332211);
        run_image(1, 1'b1);

        // Break: line held low for many bit times
        uart_rxd = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        check_eq("break_error", 32'(error), 32'd1);
        check_eq("break_cpu_reset", 32'(cpu_reset), 32'd0);
        uart_rxd = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        fill_random(2);
        run_image(2, 1'b1);

        // Address wrap past the top of memory
        fill_random(10);
        run_image(10, 1'b1);

        // Random images
        for (int k = 0; k < 5; k++) begin
            int n;
            n = $urandom_range(0, 4);
            fill_random(n);
            run_image(n, 1'b1);
        end

`ifdef UART_LOADER_CHECKSUM_EN
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_eq("model_sum", 32'(model_sum()), 32'h0A);
        run_image(1, 1'b0);
        run_image(1, 1'b1);
`endif

        // Reset in the middle of the third byte
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        check_eq("pre_abort_cpu_reset", 32'(cpu_reset), 32'd1);
        uart_rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_rxd = 1'(i & 1);
            repeat (BIT) @(negedge clk);
        end
        repeat (BIT / 2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("abort_cpu_reset", 32'(cpu_reset), 32'd0);
        check_eq("abort_mem_we", 32'(mem_we), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_error", 32'(error), 32'd0);
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        fill_random(2);
        run_image(2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
